// File: rtl/serial_8250_pkg.sv
// Shared constants for the 8250-style serial blocks: FSM state encoding,
// oversample ratio and the mid-bit tick used to qualify a start bit.
package serial_8250_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_WAIT_HI = 3'd5;

    localparam int         OVS       = 16;
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);

    // True when data plus parity bit do not match the configured parity sense.
    function automatic logic parity_bad(input logic [7:0] data, input logic pbit,
                                        input logic odd);
        return (^{data, pbit}) != odd;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-clk pulse every DIV clks, realigned to 0
// whenever restart is asserted so bit sampling tracks the start edge.
module baud_tick_gen
    import serial_8250_pkg::*;
#(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    logic [15:0] r_cnt;

    assign tick = (r_cnt == 16'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/serial_rx_8250.sv
// 8250-style serial receiver, 16x oversampled, 8N1 by default.
// Define RX_PARITY_EN for 8 data + parity + 1 stop framing with par_err reporting.
module serial_rx_8250
    import serial_8250_pkg::*;
#(
    parameter int unsigned DIV        = 27,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data_in,
    output logic       data_finish,
    output logic       frame_err,
    output logic       par_err,
    output logic       busy
);

    logic       r_sync1, r_sync2;
    logic [2:0] r_state;
    logic [3:0] r_ovs;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_fin;
    logic       r_ferr;
    logic       w_rx;
    logic       w_tick;
    logic       w_restart;
    logic       w_last;

    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx      = r_sync2;
    assign w_restart = (r_state == ST_IDLE) && !w_rx;
    assign w_last    = w_tick && (r_ovs == LAST_TICK);

    baud_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ovs    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_data   <= '0;
            r_fin    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_fin  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_state <= ST_START;
                        r_ovs   <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_ovs == MID_TICK) begin
                            r_ovs    <= '0;
                            r_bitcnt <= '0;
                            r_state  <= w_rx ? ST_IDLE : ST_DATA;
                        end else begin
                            r_ovs <= r_ovs + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    // r_ovs wraps 15 -> 0, so each sample lands mid-bit.
                    if (w_tick) begin
                        r_ovs <= r_ovs + 4'd1;
                        if (r_ovs == LAST_TICK) begin
                            r_shift  <= {w_rx, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
`ifdef RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_ovs <= r_ovs + 4'd1;
                        if (r_ovs == LAST_TICK) r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        r_ovs <= r_ovs + 4'd1;
                        if (r_ovs == LAST_TICK) begin
                            if (w_rx) begin
                                r_data  <= r_shift;
                                r_fin   <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= ST_WAIT_HI;
                            end
                        end
                    end
                end
                ST_WAIT_HI: begin
                    // A break holds the line low; wait it out for a single frame_err.
                    if (w_rx) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef RX_PARITY_EN
    logic r_par_pend;
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_pend <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            if (r_state == ST_PARITY && w_last)
                r_par_pend <= parity_bad(r_shift, w_rx, PARITY_ODD);
            if (r_state == ST_STOP && w_last && w_rx)
                r_par_err <= r_par_pend;
        end
    end

    assign par_err = r_par_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = PARITY_ODD;
    assign par_err      = 1'b0;
`endif

    assign data_in     = r_data;
    assign data_finish = r_fin;
    assign frame_err   = r_ferr;
    assign busy        = (r_state != ST_IDLE);

endmodule
